// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming SECDED memory engine.
// Optional build macro: HAMMING_STATS_EN (error statistics counters).
package hamming_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_LO = 3'd1,
    ST_RD_HI = 3'd2,
    ST_CAPT  = 3'd3,
    ST_WR_LO = 3'd4,
    ST_WR_HI = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } mode_t;

  localparam logic [1:0] FLAG_OK  = 2'b00;
  localparam logic [1:0] FLAG_SGL = 2'b01;
  localparam logic [1:0] FLAG_DBL = 2'b10;

  // Codeword bit k holds Hamming position k.
  localparam int unsigned POS_P0 = 0;
  localparam int unsigned POS_P1 = 1;
  localparam int unsigned POS_P2 = 2;
  localparam int unsigned POS_D1 = 3;
  localparam int unsigned POS_P4 = 4;
  localparam int unsigned POS_P8 = 8;

endpackage

// File: rtl/hamming_secded.sv
// Combinational SECDED (16,11) encoder and decoder/corrector.
// Encode: cw_in = {5'b0, d[11:9], d[8:1]} -> codeword.
// Decode: cw_in = codeword -> {flags, 3'b0, d[11:9], d[8:1]}.
module hamming_secded
  import hamming_pkg::*;
(
  input  logic        mode,
  input  logic [15:0] cw_in,
  output logic [15:0] result
);

  // XOR of the indices of all set bits at positions 1..15
  function automatic logic [3:0] syndrome(input logic [15:0] c);
    logic [3:0] s;
    s = 4'h0;
    for (int k = 1; k < 16; k++) begin
      s = s ^ (c[k] ? 4'(k) : 4'h0);
    end
    return s;
  endfunction

  // Place data bits, then set p1/p2/p4/p8 from the data syndrome and p0 for even overall parity
  function automatic logic [15:0] secded_encode(input logic [10:0] d);
    logic [15:0] c;
    logic [3:0]  s;
    c          = 16'h0000;
    c[POS_D1]  = d[0];
    c[7:5]     = d[3:1];
    c[15:9]    = d[10:4];
    s          = syndrome(c);
    c[POS_P1]  = s[0];
    c[POS_P2]  = s[1];
    c[POS_P4]  = s[2];
    c[POS_P8]  = s[3];
    c[POS_P0]  = ^c[15:1];
    return c;
  endfunction

  // Classify, correct a single error when the overall parity points to one, extract data
  function automatic logic [15:0] secded_decode(input logic [15:0] cw);
    logic [15:0] c;
    logic [3:0]  s;
    logic [1:0]  fl;
    logic [10:0] d;
    c = cw;
    s = syndrome(cw);
    if (^cw) begin
      fl = FLAG_SGL;
      if (s != 4'h0) begin
        c[s] = ~c[s];
      end else begin
        c = cw;
      end
    end else if (s != 4'h0) begin
      fl = FLAG_DBL;
    end else begin
      fl = FLAG_OK;
    end
    d = {c[15:9], c[7:5], c[POS_D1]};
    return {fl, 3'b000, d[10:8], d[7:0]};
  endfunction

  // Select encode or decode path from the latched mode
  always_comb begin
    result = 16'h0000;
    if (mode_t'(mode) == MODE_DEC) begin
      result = secded_decode(cw_in);
    end else begin
      result = secded_encode({cw_in[10:8], cw_in[7:0]});
    end
  end

endmodule

// File: rtl/hamming_mem_engine.sv
// Memory-to-memory Hamming SECDED engine: reads NUM_MSG two-byte messages,
// encodes or decodes/corrects them, writes two result bytes per message.
// Optional build macro: HAMMING_STATS_EN adds err_single_cnt/err_double_cnt.
module hamming_mem_engine
  import hamming_pkg::*;
#(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              mode,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
`ifdef HAMMING_STATS_EN
  ,
  output logic [7:0]        err_single_cnt,
  output logic [7:0]        err_double_cnt
`endif
);

  state_t            state_r, state_nxt_s;
  logic [6:0]        idx_r, idx_nxt_s;
  mode_t             mode_r, mode_nxt_s;
  logic              start_s;
  logic [7:0]        lo_r, hi_r;
  logic [15:0]       cw_s, result_s;
  logic [ADDR_W-1:0] off_s, addr_nxt_s;
  logic              wen_nxt_s;
  logic [7:0]        wdata_nxt_s;
  logic              done_r, wen_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        wdata_r;

  // Next-state, message index and mode latch
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    mode_nxt_s  = mode_r;
    start_s     = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (req) begin
          state_nxt_s = ST_RD_LO;
          idx_nxt_s   = 7'd0;
          mode_nxt_s  = mode_t'(mode);
          start_s     = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RD_LO: state_nxt_s = ST_RD_HI;
      ST_RD_HI: state_nxt_s = ST_CAPT;
      ST_CAPT:  state_nxt_s = ST_WR_LO;
      ST_WR_LO: state_nxt_s = ST_WR_HI;
      ST_WR_HI: begin
        if (idx_r == 7'(NUM_MSG - 1)) begin
          state_nxt_s = ST_DONE;
        end else begin
          idx_nxt_s   = idx_r + 7'd1;
          state_nxt_s = ST_RD_LO;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // The high byte arrives on mem_rdata during CAPT; use it directly there
  always_comb begin
    cw_s = {hi_r, lo_r};
    if (state_r == ST_CAPT) begin
      cw_s = {mem_rdata, lo_r};
    end else begin
      cw_s = {hi_r, lo_r};
    end
  end

  hamming_secded u_secded (
    .mode   (mode_r),
    .cw_in  (cw_s),
    .result (result_s)
  );

  // Memory-port values for the upcoming state, registered below so outputs line up with it
  always_comb begin
    off_s       = ADDR_W'({idx_nxt_s, 1'b0});
    addr_nxt_s  = '0;
    wen_nxt_s   = 1'b0;
    wdata_nxt_s = 8'h00;
    case (state_nxt_s)
      ST_RD_LO: addr_nxt_s = ADDR_W'(SRC_BASE) + off_s;
      ST_RD_HI: addr_nxt_s = ADDR_W'(SRC_BASE) + off_s + ADDR_W'(1'b1);
      ST_WR_LO: begin
        addr_nxt_s  = ADDR_W'(DST_BASE) + off_s;
        wen_nxt_s   = 1'b1;
        wdata_nxt_s = result_s[7:0];
      end
      ST_WR_HI: begin
        addr_nxt_s  = ADDR_W'(DST_BASE) + off_s + ADDR_W'(1'b1);
        wen_nxt_s   = 1'b1;
        wdata_nxt_s = result_s[15:8];
      end
      default: begin
        addr_nxt_s  = '0;
        wen_nxt_s   = 1'b0;
        wdata_nxt_s = 8'h00;
      end
    endcase
  end

  // FSM state, index, mode latch and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      idx_r   <= 7'd0;
      mode_r  <= MODE_ENC;
      done_r  <= 1'b0;
      addr_r  <= '0;
      wen_r   <= 1'b0;
      wdata_r <= 8'h00;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      mode_r  <= mode_nxt_s;
      done_r  <= (state_nxt_s == ST_DONE);
      addr_r  <= addr_nxt_s;
      wen_r   <= wen_nxt_s;
      wdata_r <= wdata_nxt_s;
    end
  end

  // Capture source bytes one cycle after their address was presented
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo_r <= 8'h00;
      hi_r <= 8'h00;
    end else if (state_r == ST_RD_HI) begin
      lo_r <= mem_rdata;
    end else if (state_r == ST_CAPT) begin
      hi_r <= mem_rdata;
    end else begin
      lo_r <= lo_r;
      hi_r <= hi_r;
    end
  end

  assign done      = done_r;
  assign mem_addr  = addr_r;
  assign mem_wen   = wen_r;
  assign mem_wdata = wdata_r;

`ifdef HAMMING_STATS_EN
  logic [7:0] sgl_cnt_r, dbl_cnt_r;

  // Saturating decode error counters, cleared when a run is accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sgl_cnt_r <= 8'h00;
      dbl_cnt_r <= 8'h00;
    end else if (start_s) begin
      sgl_cnt_r <= 8'h00;
      dbl_cnt_r <= 8'h00;
    end else if (state_r == ST_CAPT && mode_r == MODE_DEC) begin
      if (result_s[15:14] == FLAG_SGL && sgl_cnt_r != 8'hFF) begin
        sgl_cnt_r <= sgl_cnt_r + 8'd1;
      end else begin
        sgl_cnt_r <= sgl_cnt_r;
      end
      if (result_s[15:14] == FLAG_DBL && dbl_cnt_r != 8'hFF) begin
        dbl_cnt_r <= dbl_cnt_r + 8'd1;
      end else begin
        dbl_cnt_r <= dbl_cnt_r;
      end
    end else begin
      sgl_cnt_r <= sgl_cnt_r;
      dbl_cnt_r <= dbl_cnt_r;
    end
  end

  assign err_single_cnt = sgl_cnt_r;
  assign err_double_cnt = dbl_cnt_r;
`endif

endmodule
